// File: rtl/matmul_bus_sequencer_if.sv
// Stream-in, stream-out and control-block bus signals of the matmul bus sequencer.
// master = sequencer side, slave = word source / result sink / control block side.
interface matmul_bus_sequencer_if #(
  parameter int pWordSize = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [pWordSize-1:0] in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [pWordSize-1:0] out_data;
  logic                 out_last;

  logic                 BusRD;
  logic                 BusWR;
  logic [14:0]          BusAddr;
  logic [31:0]          BusDataOut;
  logic [31:0]          BusDataIn;

  modport master (
    input  in_valid, in_data, out_ready, BusDataIn,
    output in_ready, out_valid, out_data, out_last,
    output BusRD, BusWR, BusAddr, BusDataOut
  );

  modport slave (
    output in_valid, in_data, out_ready, BusDataIn,
    input  in_ready, out_valid, out_data, out_last,
    input  BusRD, BusWR, BusAddr, BusDataOut
  );
endinterface

// File: rtl/matmul_bus_sequencer.sv
// Scan-loads matrix/vector words into the matmul control block, reads N results back and streams them out (valid/ready).
// Bus outputs are registered (one cycle after acceptance); define MATMUL_SEQ_MATRIX_REUSE_EN to let start_reuse skip the matrix load.
module matmul_bus_sequencer #(
  parameter int pVectorSize  = 8,
  parameter int pWordSize    = 8,
  parameter int pComputeWait = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  logic start_reuse,
  output logic busy,
  output logic done,
  matmul_bus_sequencer_if.master bus
);
  localparam int cMatWords = pVectorSize * pVectorSize;
  localparam int cCntW     = $clog2(cMatWords + 1);
  localparam int cRdW      = $clog2(pVectorSize + 1);
  localparam int cIdxW     = $clog2(pVectorSize);
  localparam int cWaitW    = 4;

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, WAIT, READ, SEND} state_t;
  state_t state, nextState;

  logic [cCntW-1:0]     wordCnt;
  logic [cWaitW-1:0]    waitCnt;
  logic [cRdW-1:0]      rdCnt;
  logic [cIdxW-1:0]     sendCnt;
  logic [pWordSize-1:0] resBuf [pVectorSize];

  logic inAccept, outAccept;
  logic lastMatWord, lastVecWord, waitDone, readDone, lastSend;
  logic unusedBusBits;

  assign inAccept    = bus.in_valid && bus.in_ready;
  assign outAccept   = bus.out_valid && bus.out_ready;
  assign lastMatWord = (wordCnt == cCntW'(cMatWords - 1));
  assign lastVecWord = (wordCnt == cCntW'(pVectorSize - 1));
  assign waitDone    = (waitCnt == cWaitW'(pComputeWait));
  assign readDone    = (rdCnt == cRdW'(pVectorSize));
  assign lastSend    = (sendCnt == cIdxW'(pVectorSize - 1));
  assign unusedBusBits = ^bus.BusDataIn;

`ifndef MATMUL_SEQ_MATRIX_REUSE_EN
  logic unusedReuse;
  assign unusedReuse = start_reuse;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState     = state;
    busy          = (state != IDLE);
    bus.in_ready  = (state == LOAD_M) || (state == LOAD_V);
    bus.out_valid = (state == SEND);
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (state == SEND) begin
      bus.out_data = resBuf[sendCnt];
      bus.out_last = lastSend;
    end
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MATMUL_SEQ_MATRIX_REUSE_EN
          nextState = start_reuse ? LOAD_V : LOAD_M;
`else
          nextState = LOAD_M;
`endif
        end
      end
      LOAD_M: if (inAccept && lastMatWord) nextState = LOAD_V;
      LOAD_V: if (inAccept && lastVecWord) nextState = WAIT;
      WAIT:   if (waitDone) nextState = READ;
      READ:   if (readDone) nextState = SEND;
      SEND:   if (outAccept && lastSend) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wordCnt        <= '0;
      waitCnt        <= '0;
      rdCnt          <= '0;
      sendCnt        <= '0;
      done           <= 1'b0;
      bus.BusWR      <= 1'b0;
      bus.BusRD      <= 1'b0;
      bus.BusAddr    <= '0;
      bus.BusDataOut <= '0;
      for (int i = 0; i < pVectorSize; i++) resBuf[i] <= '0;
    end else begin
      bus.BusWR <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          wordCnt <= '0;
          waitCnt <= '0;
          sendCnt <= '0;
        end
        LOAD_M, LOAD_V: begin
          if (inAccept) begin
            bus.BusWR      <= 1'b1;
            bus.BusAddr    <= (state == LOAD_V) ? 15'd1 : 15'd0;
            bus.BusDataOut <= 32'(bus.in_data);
            if ((state == LOAD_M && lastMatWord) || (state == LOAD_V && lastVecWord))
              wordCnt <= '0;
            else
              wordCnt <= wordCnt + cCntW'(1);
            waitCnt <= '0;
          end
        end
        WAIT: begin
          // The cycle carrying the last WR counts as zero; RD starts after pComputeWait idle cycles.
          if (waitDone) begin
            waitCnt     <= '0;
            rdCnt       <= '0;
            bus.BusRD   <= 1'b1;
            bus.BusAddr <= '0;
          end else begin
            waitCnt <= waitCnt + cWaitW'(1);
          end
        end
        READ: begin
          // The control block's holder lags the address by one cycle, so Addr=r shows result r-1.
          if (rdCnt != '0)
            resBuf[cIdxW'(rdCnt - cRdW'(1))] <= bus.BusDataIn[pWordSize-1:0];
          if (readDone) begin
            bus.BusRD   <= 1'b0;
            bus.BusAddr <= '0;
          end else begin
            rdCnt       <= rdCnt + cRdW'(1);
            bus.BusAddr <= 15'(rdCnt + cRdW'(1));
          end
        end
        SEND: begin
          if (outAccept) begin
            if (lastSend) begin
              sendCnt <= '0;
              done    <= 1'b1;
            end else begin
              sendCnt <= sendCnt + cIdxW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_bus_sequencer.sv
// Randomized self-checking bench: behavioural control-block model plus arithmetic reference for the dot products.
module tb_matmul_bus_sequencer;
  localparam int N    = 8;
  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int MASK = (1 << W) - 1;
`ifdef MATMUL_SEQ_MATRIX_REUSE_EN
  localparam bit kReuseEn = 1'b1;
`else
  localparam bit kReuseEn = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset, start, start_reuse, busy, done;

  matmul_bus_sequencer_if #(.pWordSize(W)) busIf ();

  matmul_bus_sequencer #(.pVectorSize(N), .pWordSize(W), .pComputeWait(CW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .start_reuse(start_reuse),
    .busy(busy), .done(done), .bus(busIf)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Control block: scan chains shifted by WR, registered result holder updated by in-range RD.
  int mStore[$];
  int vStore[$];
  int rdAddrs[$];
  int wr0 = 0, wr1 = 0, bothCount = 0, upperNonzero = 0;
  longint cyc = 0, lastWrCyc = 0, firstRdCyc = -1;
  logic [W-1:0] holder = '0;
  logic [31:0]  dataInNext;

  function automatic int dotModel(input int k);
    int s = 0;
    if (mStore.size() != N*N || vStore.size() != N) return 0;
    for (int j = 0; j < N; j++) s += mStore[k*N + j] * vStore[j];
    return s & MASK;
  endfunction

  always @(posedge Clk) begin
    cyc++;
    if (busIf.BusWR && busIf.BusRD) bothCount++;
    if (busIf.BusWR) begin
      lastWrCyc = cyc;
      if (busIf.BusDataOut[31:W] != '0) upperNonzero++;
      if (busIf.BusAddr == 15'd0) begin
        wr0++;
        mStore.push_back(int'(busIf.BusDataOut[W-1:0]));
        if (mStore.size() > N*N) void'(mStore.pop_front());
      end else if (busIf.BusAddr == 15'd1) begin
        wr1++;
        vStore.push_back(int'(busIf.BusDataOut[W-1:0]));
        if (vStore.size() > N) void'(vStore.pop_front());
      end
    end
    if (busIf.BusRD) begin
      rdAddrs.push_back(int'(busIf.BusAddr));
      if (firstRdCyc < 0) firstRdCyc = cyc;
      if (busIf.BusAddr < N) holder = W'(dotModel(int'(busIf.BusAddr)));
    end
    dataInNext = $urandom();
    dataInNext[W-1:0] = holder;
    busIf.BusDataIn <= dataInNext;
  end

  int curM[N*N];
  int curV[N];

  task automatic setIdentity();
    foreach (curM[i]) curM[i] = ((i / N) == (i % N)) ? 1 : 0;
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, " busy"}, busy, 0);
    checkVal({tag, " done"}, done, 0);
    checkVal({tag, " in_ready"}, busIf.in_ready, 0);
    checkVal({tag, " out_valid"}, busIf.out_valid, 0);
    checkVal({tag, " out_last"}, busIf.out_last, 0);
    checkVal({tag, " out_data"}, busIf.out_data, 0);
    checkVal({tag, " BusRD"}, busIf.BusRD, 0);
    checkVal({tag, " BusWR"}, busIf.BusWR, 0);
    checkVal({tag, " BusAddr"}, busIf.BusAddr, 0);
    checkVal({tag, " BusDataOut"}, busIf.BusDataOut, 0);
  endtask

  // validMode: 0 always, 1 every other cycle, 2 random. readyMode: 0 always, 1 stall 5 cycles at k=3, 2 random.
  task automatic runJob(input string name, input bit reuse, input int validMode, input int readyMode);
    int words[$];
    int idx, k, stall, budget, wr0Base, wr1Base;
    bit loadM, sawValid;
    logic v, r;
    logic [W-1:0] expRes[N];

    loadM = !(reuse && kReuseEn);
    if (loadM) foreach (curM[i]) words.push_back(curM[i]);
    foreach (curV[i]) words.push_back(curV[i]);
    for (int row = 0; row < N; row++) begin
      int s = 0;
      for (int j = 0; j < N; j++) s += curM[row*N + j] * curV[j];
      expRes[row] = W'(s & MASK);
    end

    wr0Base = wr0;
    wr1Base = wr1;
    rdAddrs.delete();
    firstRdCyc = -1;

    @(negedge Clk);
    start = 1'b1;
    start_reuse = reuse;
    @(negedge Clk);
    start = 1'b0;
    start_reuse = 1'b0;
    checkVal({name, " busy after start"}, busy, 1);

    idx = 0;
    budget = 0;
    while (idx < words.size() && budget < 2000) begin
      case (validMode)
        0:       v = 1'b1;
        1:       v = budget[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      busIf.in_valid = v;
      busIf.in_data  = v ? W'(words[idx]) : W'($urandom());
      if (v && busIf.in_ready) idx++;
      budget++;
      @(negedge Clk);
    end
    busIf.in_valid = 1'b0;
    if (idx < words.size()) checkVal({name, " load timeout words"}, idx, words.size());

    k = 0;
    stall = 0;
    budget = 0;
    sawValid = 1'b0;
    while (k < N && budget < 2000) begin
      case (readyMode)
        0:       r = 1'b1;
        1:       r = !(k == 3 && stall < 5);
        default: r = 1'(($urandom_range(0, 1)));
      endcase
      if (sawValid) checkVal({name, " out_valid held"}, busIf.out_valid, 1);
      if (busIf.out_valid) begin
        sawValid = 1'b1;
        checkVal({name, " out_data"}, busIf.out_data, expRes[k]);
        checkVal({name, " out_last"}, busIf.out_last, (k == N-1));
        if (readyMode == 1 && k == 3 && !r) stall++;
      end
      busIf.out_ready = r;
      if (busIf.out_valid && r) k++;
      budget++;
      @(negedge Clk);
    end
    busIf.out_ready = 1'b0;
    if (k < N) checkVal({name, " send timeout results"}, k, N);

    checkVal({name, " done pulse"}, done, 1);
    checkVal({name, " busy after last"}, busy, 0);
    checkVal({name, " out_valid after last"}, busIf.out_valid, 0);
    @(negedge Clk);
    checkVal({name, " done one cycle"}, done, 0);

    checkVal({name, " WR count addr0"}, wr0 - wr0Base, loadM ? N*N : 0);
    checkVal({name, " WR count addr1"}, wr1 - wr1Base, N);
    checkVal({name, " RD count"}, rdAddrs.size(), N + 1);
    foreach (rdAddrs[i]) checkVal({name, " RD address"}, rdAddrs[i], i);
    checkVal({name, " compute wait cycles"}, firstRdCyc - lastWrCyc - 1, CW);
  endtask

  initial begin
    Reset = 1'b0;
    start = 1'b0;
    start_reuse = 1'b0;
    busIf.in_valid = 1'b0;
    busIf.in_data = '0;
    busIf.out_ready = 1'b0;
    repeat (2) @(negedge Clk);
    checkIdle("reset");
    Reset = 1'b1;
    @(negedge Clk);
    checkIdle("idle after reset");

    setIdentity();
    foreach (curV[i]) curV[i] = i + 1;
    runJob("identity", 1'b0, 0, 0);

    foreach (curM[i]) curM[i] = 8'hFF;
    foreach (curV[i]) curV[i] = 8'hFF;
    runJob("all ff", 1'b0, 0, 0);

    setIdentity();
    foreach (curV[i]) curV[i] = i + 1;
    runJob("stall", 1'b0, 0, 1);
    runJob("valid gaps", 1'b0, 1, 0);

    // Abandon a job after 20 matrix words.
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    checkVal("abort busy", busy, 1);
    for (int i = 0; i < 20; i++) begin
      busIf.in_valid = 1'b1;
      busIf.in_data = W'(curM[i]);
      @(negedge Clk);
    end
    Reset = 1'b0;
    start = 1'b1;
    #1;
    checkIdle("mid-job reset");
    repeat (3) @(negedge Clk);
    checkIdle("held reset");
    start = 1'b0;
    busIf.in_valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    checkIdle("after abort");
    runJob("after abort", 1'b0, 0, 0);

    foreach (curV[i]) curV[i] = 10 + i;
    runJob("reuse", 1'b1, 0, 0);

    for (int t = 0; t < 3; t++) begin
      foreach (curM[i]) curM[i] = int'($urandom_range(0, MASK));
      foreach (curV[i]) curV[i] = int'($urandom_range(0, MASK));
      runJob("random", 1'b0, 2, 2);
    end
    foreach (curV[i]) curV[i] = int'($urandom_range(0, MASK));
    runJob("random reuse", 1'b1, 2, 2);

    checkVal("RD and WR overlap", bothCount, 0);
    checkVal("DataOut upper bits nonzero", upperNonzero, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion of all jobs");
    $fatal(1);
  end
endmodule

// File: doc/matmul_bus_sequencer.md
Name: matmul_bus_sequencer

Overview:
- Host-side bus master that sits directly upstream of the scan-mode integer matrix-multiply control block, on its Clk/RD/WR/Addr/DataIn/DataOut bus.
- Per job: accepts a stream of matrix and vector words and scan-writes them into the control block. After a fixed compute wait it reads back all pVectorSize dot-product results and streams them out with a valid/ready handshake.
- Replaces the testbench-driven bus sequence for system-level runs.

Parameters:
- pVectorSize, 8, vector length N; the matrix is N x N.
- pWordSize, 8, word width W for matrix, vector and result words.
- pComputeWait, 2, idle cycles between the last vector WR and the first RD (legal range 1..15).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  active-low asynchronous reset.
- start  input  1  begin a job; sampled only in IDLE.
- start_reuse  input  1  with start: skip the matrix load (see Optional Feature).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last result is accepted.
- in_valid  input  1  input word valid.
- in_ready  output  1  sequencer accepts in_data this cycle.
- in_data  input  pWordSize  matrix/vector word.
- out_valid  output  1  result word valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  pWordSize  result word k.
- out_last  output  1  high with out_valid on result N-1.
- BusRD  output  1  drives the control block RD.
- BusWR  output  1  drives the control block WR.
- BusAddr  output  15  drives the control block Addr.
- BusDataOut  output  32  drives the control block DataIn; in_data zero-extended.
- BusDataIn  input  32  control block DataOut; only bits [W-1:0] are used.

Behaviour:
- Reset (async, Reset=0): state IDLE. busy, done, in_ready, out_valid, out_last, BusRD, BusWR all 0. BusAddr=0, BusDataOut=0, out_data=0. All counters and the result buffer are cleared. Reset mid-job abandons the job; no partial results are emitted.
- Registered bus outputs: a word accepted at edge t (in_valid&in_ready) produces BusWR=1 with BusAddr/BusDataOut for exactly the following cycle. BusWR is otherwise 0.
- IDLE: start=1 -> LOAD_M, clearing the word counter. If start_reuse=1 and the feature is enabled -> LOAD_V instead.
- LOAD_M: in_ready=1. Each accepted word issues a WR to BusAddr=0. After N*N accepted words -> LOAD_V.
  - Stream order is row-major: word m is matrix row m/N, column m%N. Scan shifting places the first word at the lowest slot.
- LOAD_V: in_ready=1. Each accepted word issues a WR to BusAddr=1. After N words -> WAIT. Word j is vector element j.
- in_valid gaps in either LOAD state stall the counter; no WR is issued in gap cycles.
- WAIT: in_ready=0. Wait counter runs pComputeWait cycles after the cycle carrying the last BusWR, then -> READ.
- READ: N+1 consecutive cycles with BusRD=1 and BusAddr=r for r=0..N. Cycle N uses Addr=N, out of range, so the holder is not updated.
  - In cycle r+1, BusDataIn[W-1:0] is captured into result buffer slot r. This accounts for the one-cycle registered holder in the control block.
  - After cycle N: BusRD=0, -> SEND.
- SEND: out_valid=1, out_data=buffer[k], out_last=(k==N-1). k advances on out_valid&out_ready.
  - out_data is held stable while out_ready=0.
  - On acceptance of k=N-1 -> IDLE, with done=1 for one cycle.
- Result arithmetic: result k = sum over j of M[k][j]*v[j], modulo 2^W. The sequencer passes it through unmodified.
- start is ignored while busy=1. start and start_reuse have no effect outside IDLE.
- Never assert BusRD and BusWR in the same cycle.

Optional Feature:
- Macro: MATMUL_SEQ_MATRIX_REUSE_EN.
- Defined: start with start_reuse=1 goes IDLE -> LOAD_V, leaving the previously loaded matrix in the control block. Only N words are consumed, then WAIT/READ/SEND as normal.
- Undefined: the start_reuse port remains but is ignored, and every job loads the full matrix.

Test Plan:
- Identity matrix (ones at m=k*N+k), vector 1..8, out_ready=1 -> out_data 1,2,...,8; out_last on 8; done one cycle after the last acceptance.
- All matrix and vector words 0xFF -> every result 8 (each product 65025 mod 256 = 1, times 8 = 8).
- Identity run with out_ready=0 for 5 cycles while k=3 -> out_data stays 4 with out_valid high; the sequence then resumes 4..8 with no loss or duplication.
- in_valid toggled every other cycle during load -> exactly 64 WR to Addr 0 then 8 WR to Addr 1; BusWR count 72; results identical to the gap-free run.
- Reset driven low after 20 matrix words, then a fresh identity job -> outputs idle during reset; new job gives 1..8.
- MATMUL_SEQ_MATRIX_REUSE_EN: identity job, then start+start_reuse with vector 10..17 -> only 8 WR cycles; results 10..17.
